// File: rtl/nibble_pack_4to8_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_pack_4to8_if
// Description : Nibble-in / byte-out handshake bundle for nibble_pack_4to8.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_pack_4to8_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]      din;
    logic            din_valid;
    logic            din_ready;
    logic            flush;
    logic [7:0]      dout;
    logic            dout_valid;
    logic            dout_ready;
    logic [c_LW-1:0] level;
    logic            odd_pending;

    modport slave (
        input  din, din_valid, flush, dout_ready,
        output din_ready, dout, dout_valid, level, odd_pending
    );

    modport master (
        output din, din_valid, flush, dout_ready,
        input  din_ready, dout, dout_valid, level, odd_pending
    );
endinterface
`default_nettype wire

// File: rtl/nibble_pack_4to8.sv
`default_nettype none
// ============================================================================
// Module      : nibble_pack_4to8
// Description : Packs MSB-first nibble pairs into bytes, buffered in a FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_pack_4to8 #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [3:0]  PAD_NIBBLE = 4'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    nibble_pack_4to8_if.slave  bus
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        PH_EMPTY = 1'b0,
        PH_HELD  = 1'b1
    } phase_t;

    phase_t          r_phase;
    phase_t          w_phase_next;
    logic [3:0]      r_hold;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_count;

    logic            w_full;
    logic            w_din_ready;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_load_hold;
    logic [7:0]      w_push_data;

    assign w_full      = (r_count == c_FULL);
    // Ready depends only on registered state, never on dout_ready.
    assign w_din_ready = (r_phase == PH_EMPTY) || !w_full;
    assign w_accept    = bus.din_valid && w_din_ready;
    assign w_pop       = (r_count != '0) && bus.dout_ready;

    always_comb begin
        w_phase_next = r_phase;
        w_push       = 1'b0;
        w_load_hold  = 1'b0;
        w_push_data  = {r_hold, bus.din};
        if (w_accept) begin
            if (r_phase == PH_EMPTY) begin
                w_load_hold  = 1'b1;
                w_phase_next = PH_HELD;
            end else begin
                w_push       = 1'b1;
                w_phase_next = PH_EMPTY;
            end
        end else if (bus.flush && (r_phase == PH_HELD) && !w_full) begin
            // A flush only pads when no nibble arrives to complete the pair.
            w_push       = 1'b1;
            w_push_data  = {r_hold, PAD_NIBBLE};
            w_phase_next = PH_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_EMPTY;
            r_hold  <= 4'h0;
        end else begin
            r_phase <= w_phase_next;
            if (w_load_hold) begin
                r_hold <= bus.din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LW'(1);
                2'b01:   r_count <= r_count - c_LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.din_ready   = w_din_ready;
    assign bus.dout        = r_mem[r_rd_ptr];
    assign bus.dout_valid  = (r_count != '0);
    assign bus.level       = r_count;
    assign bus.odd_pending = (r_phase == PH_HELD);
endmodule
`default_nettype wire

// File: tb/tb_nibble_pack_4to8.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_pack_4to8
// Description : Randomized bench for nibble_pack_4to8 against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_pack_4to8;
    localparam int         c_DEPTH = 4;
    localparam logic [3:0] c_PAD   = 4'h0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_pack_4to8_if #(.FIFO_DEPTH(c_DEPTH)) bus ();

    nibble_pack_4to8 #(.FIFO_DEPTH(c_DEPTH), .PAD_NIBBLE(c_PAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic       m_phase = 1'b0;
    logic [3:0] m_hold  = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !m_phase || (exp_q.size() < c_DEPTH);
    endfunction

    // Byte-level reference: a queue of completed bytes plus one optional held nibble.
    task automatic model_step();
        logic full, acc;
        if (!rst_n) return;
        full = (exp_q.size() == c_DEPTH);
        acc  = bus.din_valid && m_ready();
        if (exp_q.size() > 0 && bus.dout_ready) void'(exp_q.pop_front());
        if (acc) begin
            if (!m_phase) begin
                m_hold  = bus.din;
                m_phase = 1'b1;
            end else begin
                exp_q.push_back({m_hold, bus.din});
                m_phase = 1'b0;
            end
        end else if (bus.flush && m_phase && !full) begin
            exp_q.push_back({m_hold, c_PAD});
            m_phase = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase = 1'b0;
        m_hold  = 4'h0;
    endtask

    always @(negedge clk) begin
        check("din_ready", {31'b0, bus.din_ready}, {31'b0, m_ready()});
        check("dout_valid", {31'b0, bus.dout_valid}, {31'b0, exp_q.size() != 0});
        check("level", {29'b0, bus.level}, exp_q.size());
        check("odd_pending", {31'b0, bus.odd_pending}, {31'b0, m_phase});
        if (exp_q.size() != 0) check("dout", {24'b0, bus.dout}, {24'b0, exp_q[0]});
        else check("dout_known", {31'b0, !$isunknown(bus.dout)}, 32'd1);
        if (bus.dout_valid && bus.dout_ready) obs_q.push_back(bus.dout);
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic feed(input logic [3:0] n);
        bus.din       = n;
        bus.din_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        bus.din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_log(input string name, input logic [7:0] exp [$]);
        check({name, "_count"}, obs_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
            check(name, {24'b0, obs_q[i]}, {24'b0, exp[i]});
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.din        = 4'h0;
        bus.din_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        check("rst_dout", {24'b0, bus.dout}, 32'h00);
        check("rst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("rst_din_ready", {31'b0, bus.din_ready}, 32'd1);
        check("rst_level", {29'b0, bus.level}, 32'd0);
        check("rst_odd", {31'b0, bus.odd_pending}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back stream with no backpressure.
        obs_q.delete();
        bus.dout_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            feed(4'(i));
            check("stream_din_ready", {31'b0, bus.din_ready}, 32'd1);
            check("stream_level_le1", {31'b0, bus.level <= 1}, 32'd1);
        end
        idle(3);
        check_log("stream", '{8'h12, 8'h34, 8'h56, 8'h78});

        // Fill to full, then a single pop frees room for the 10th nibble.
        obs_q.delete();
        bus.dout_ready = 1'b0;
        for (int i = 1; i <= 9; i++) feed(4'(i));
        bus.din = 4'hA;
        bus.din_valid = 1'b1;
        tick();
        check("full_level", {29'b0, bus.level}, 32'd4);
        check("full_odd", {31'b0, bus.odd_pending}, 32'd1);
        check("full_din_ready", {31'b0, bus.din_ready}, 32'd0);
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        check("pop_din_ready", {31'b0, bus.din_ready}, 32'd1);
        check("pop_level", {29'b0, bus.level}, 32'd3);
        tick();
        bus.din_valid = 1'b0;
        check("refill_level", {29'b0, bus.level}, 32'd4);
        check("refill_odd", {31'b0, bus.odd_pending}, 32'd0);
        bus.dout_ready = 1'b1;
        idle(6);
        check_log("fill", '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A});

        // Flush pads a trailing odd nibble; flush with nothing held is inert.
        obs_q.delete();
        feed(4'hA);
        feed(4'hB);
        feed(4'hC);
        bus.din_valid = 1'b0;
        bus.flush     = 1'b1;
        tick();
        check("flush_odd", {31'b0, bus.odd_pending}, 32'd0);
        idle(6);
        bus.flush = 1'b0;
        check_log("flush", '{8'hAB, 8'hC0});

        // Flush while full waits for space and keeps ordering.
        obs_q.delete();
        bus.dout_ready = 1'b0;
        for (int i = 1; i <= 9; i++) feed(4'(i));
        bus.din_valid = 1'b0;
        bus.flush     = 1'b1;
        idle(3);
        check("flushfull_level", {29'b0, bus.level}, 32'd4);
        check("flushfull_odd", {31'b0, bus.odd_pending}, 32'd1);
        bus.dout_ready = 1'b1;
        idle(8);
        bus.flush = 1'b0;
        check_log("flushfull", '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90});

        // Randomized traffic, with a backpressure-heavy stretch to exercise full.
        for (int i = 0; i < 600; i++) begin
            bus.din        = 4'($urandom_range(0, 15));
            bus.din_valid  = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.dout_ready = (i % 200 < 60) ? ($urandom_range(0, 4) == 0)
                                            : ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.flush      = 1'b0;
        bus.dout_ready = 1'b1;
        idle(8);

        // Asynchronous reset in the middle of traffic.
        bus.flush = 1'b1;
        idle(2);
        bus.flush = 1'b0;
        obs_q.delete();
        bus.dout_ready = 1'b0;
        for (int i = 1; i <= 7; i++) feed(4'(i));
        bus.din_valid = 1'b0;
        check("prerst_level", {29'b0, bus.level}, 32'd3);
        check("prerst_odd", {31'b0, bus.odd_pending}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_dout", {24'b0, bus.dout}, 32'h00);
        check("arst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        check("arst_din_ready", {31'b0, bus.din_ready}, 32'd1);
        check("arst_level", {29'b0, bus.level}, 32'd0);
        check("arst_odd", {31'b0, bus.odd_pending}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.dout_ready = 1'b1;
        feed(4'h5);
        feed(4'h6);
        idle(3);
        check_log("after_rst", '{8'h56});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
